// File: rtl/line_drawer_cmd_queue.sv
// Accel-bus front end for the line drawer: stages four-word line commands, queues DEPTH of them
// and dispatches them back-to-back. Define LINE_QUEUE_STATUS_EN to expose a readable status word.
module line_drawer_cmd_queue #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned COORD_WIDTH = 16,
   parameter int unsigned DEPTH       = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   accel_can_read,
   output logic                   accel_can_write,
   input  logic                   accel_read_enable,
   input  logic                   accel_write_enable,
   output logic [DATA_WIDTH-1:0]  accel_read_data,
   input  logic [DATA_WIDTH-1:0]  accel_write_data,
   output logic                   line_drawer_start,
   input  logic                   line_drawer_ready,
   output logic [COORD_WIDTH-1:0] line_drawer_x1,
   output logic [COORD_WIDTH-1:0] line_drawer_y1,
   output logic [COORD_WIDTH-1:0] line_drawer_x2,
   output logic [COORD_WIDTH-1:0] line_drawer_y2
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CmdW = 4 * COORD_WIDTH;
   localparam logic [PtrW-1:0] PtrOne = 1;
   localparam logic [PtrW:0] CntOne = 1;
   localparam logic [PtrW:0] CntFull = (PtrW + 1)'(DEPTH);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   logic [1:0]             word_idx_q;
   logic [COORD_WIDTH-1:0] x1_stg_q, y1_stg_q, x2_stg_q;
   logic [COORD_WIDTH-1:0] wr_coord;
   logic [CmdW-1:0]        mem_q [DEPTH];
   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]          count_q, count_d;
   logic [CmdW-1:0]        cmd_q;
   logic                   start_q;
   logic                   full, empty, wr_accept, push, pop, busy;
   state_e                 state_q, state_d;
   logic                   unused_inputs;

   assign wr_coord        = accel_write_data[COORD_WIDTH-1:0];
   assign full            = (count_q == CntFull);
   assign empty           = (count_q == '0);
   // Only the completing word has to wait for FIFO space.
   assign accel_can_write = (word_idx_q != 2'd3) || !full;
   assign wr_accept       = accel_write_enable && accel_can_write;
   assign push            = wr_accept && (word_idx_q == 2'd3);
   assign pop             = (state_q == StIdle) && !empty && line_drawer_ready;
   assign unused_inputs   = ^{accel_read_enable, accel_write_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_idx_q <= '0;
         x1_stg_q   <= '0;
         y1_stg_q   <= '0;
         x2_stg_q   <= '0;
      end else if (wr_accept) begin
         word_idx_q <= word_idx_q + 2'd1;
         unique case (word_idx_q)
            2'd0:    x1_stg_q <= wr_coord;
            2'd1:    y1_stg_q <= wr_coord;
            2'd2:    x2_stg_q <= wr_coord;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {x1_stg_q, y1_stg_q, x2_stg_q, wr_coord};
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cmd_q    <= '0;
         start_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         start_q <= pop;
         if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
            cmd_q    <= mem_q[rd_ptr_q];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // The start cycle ignores ready; the drawer may still report idle then.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (pop) state_d = StBusy;
         StBusy:  if (!start_q && line_drawer_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy              = (state_q == StBusy);
      line_drawer_start = start_q;
      line_drawer_x1    = cmd_q[4*COORD_WIDTH-1 -: COORD_WIDTH];
      line_drawer_y1    = cmd_q[3*COORD_WIDTH-1 -: COORD_WIDTH];
      line_drawer_x2    = cmd_q[2*COORD_WIDTH-1 -: COORD_WIDTH];
      line_drawer_y2    = cmd_q[COORD_WIDTH-1 -: COORD_WIDTH];
   end

`ifdef LINE_QUEUE_STATUS_EN
   assign accel_can_read = rst_n;

   always_comb begin
      accel_read_data                   = '0;
      accel_read_data[DATA_WIDTH-1]     = busy;
      accel_read_data[DATA_WIDTH-2 -: 2] = word_idx_q;
      accel_read_data[PtrW:0]           = count_q;
   end
`else
   logic unused_busy;
   assign unused_busy     = busy;
   assign accel_can_read  = 1'b0;
   assign accel_read_data = '0;
`endif

endmodule
